// File: rtl/onebit_progmem_if.sv
// Load port and fetch path between the program memory and its loader / CPU.
// The master side is the loader plus the CPU fetch; the slave side is the memory.
interface onebit_progmem_if #(
    parameter int ADDR_W = 1
);
    logic              load_start;
    logic              load_valid;
    logic              load_bit;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W-1:0] addr;
    logic              data;

    modport master (
        output load_start, load_valid, load_bit, addr,
        input  load_ready, load_done, data
    );

    modport slave (
        input  load_start, load_valid, load_bit, addr,
        output load_ready, load_done, data
    );
endinterface

// File: rtl/onebit_progmem.sv
// 1-bit-wide program store with a serial loader; holds the CPU in reset
// until a complete program has been written.
module onebit_progmem #(
    parameter int ADDR_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    onebit_progmem_if.slave  bus,
    output logic             cpu_reset,
    output logic             busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [DEPTH-1:0]  mem;
    logic              accept;

    // Ready is a pure state decode so valid never loops back into it.
    assign bus.load_ready = (state == LOAD);
    assign busy           = (state != RUN);
    assign bus.data       = mem[bus.addr];
    assign accept         = (state == LOAD) && bus.load_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            wptr          <= '0;
            mem           <= '0;
            cpu_reset     <= 1'b0;
            bus.load_done <= 1'b0;
        end else begin
            bus.load_done <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_reset <= 1'b0;
                    if (bus.load_start) begin
                        state <= LOAD;
                        wptr  <= '0;
                    end
                end
                LOAD: begin
                    cpu_reset <= 1'b0;
                    if (accept) begin
                        mem[wptr] <= bus.load_bit;
                        wptr      <= wptr + 1'b1;
                        // Last address: release the CPU on the same edge.
                        if (wptr == ADDR_W'(DEPTH - 1)) begin
                            state         <= RUN;
                            cpu_reset     <= 1'b1;
                            bus.load_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.load_start) begin
                        state     <= LOAD;
                        wptr      <= '0;
                        cpu_reset <= 1'b0;
                    end else begin
                        cpu_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_reset <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_onebit_progmem.sv
// Bench for onebit_progmem: a vector table on a 2-entry instance, directed
// sequences and random traffic on an 8-entry instance against a program model.
module tb_onebit_progmem;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset1, reset3;
    logic cpu1, busy1, cpu3, busy3;

    onebit_progmem_if #(.ADDR_W(1)) b1 ();
    onebit_progmem_if #(.ADDR_W(3)) b3 ();

    onebit_progmem #(.ADDR_W(1)) u1 (
        .clock(clock), .reset(reset1), .bus(b1.slave), .cpu_reset(cpu1), .busy(busy1)
    );
    onebit_progmem #(.ADDR_W(3)) u3 (
        .clock(clock), .reset(reset3), .bus(b3.slave), .cpu_reset(cpu3), .busy(busy3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Program model for the 8-entry instance: which phase the loader is in,
    // how many bits of the current program have arrived, and the stored bits.
    bit m_mem[8];
    bit m_loading, m_running, m_done;
    int m_cnt;

    function automatic void m_step(bit rst, bit start, bit valid, bit b);
        if (!rst) begin
            foreach (m_mem[i]) m_mem[i] = 1'b0;
            m_loading = 0; m_running = 0; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_loading) begin
                if (valid) begin
                    m_mem[m_cnt] = b;
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_loading = 0; m_running = 1; m_done = 1; m_cnt = 0;
                    end
                end
            end else if (start) begin
                m_loading = 1; m_running = 0; m_cnt = 0;
            end
        end
    endfunction

    task automatic step3(input string tag, input bit start, input bit valid,
                         input bit b, input logic [2:0] a);
        b3.load_start = start; b3.load_valid = valid; b3.load_bit = b; b3.addr = a;
        @(posedge clock);
        m_step(reset3, start, valid, b);
        #1;
        chk({tag, ".ready"}, b3.load_ready, m_loading);
        chk({tag, ".done"},  b3.load_done,  m_done);
        chk({tag, ".cpu"},   cpu3,          m_running);
        chk({tag, ".busy"},  busy3,         !m_running);
        chk({tag, ".data"},  b3.data,       m_mem[a]);
    endtask

    task automatic read_all3(output logic [7:0] v);
        for (int a = 0; a < 8; a++) begin
            b3.addr = 3'(a);
            #1;
            v[a] = b3.data;
        end
    endtask

    typedef struct {
        logic rst, start, valid, bitv, addr;
        logic ready, done, cpu, busy, data;
    } vec_t;

    vec_t tbl[15];
    logic [7:0] rd;
    logic [7:0] prog;
    int acc;

    initial begin
        reset1 = 0; reset3 = 0;
        b1.load_start = 0; b1.load_valid = 0; b1.load_bit = 0; b1.addr = '0;
        b3.load_start = 0; b3.load_valid = 0; b3.load_bit = 0; b3.addr = '0;

        //          rst st vl bt ad | rdy dn cpu bsy dat
        tbl[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
        tbl[1]  = '{0, 0, 1, 1, 1,   0, 0, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 0,   1, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 1, 1, 0,   1, 0, 0, 1, 1};
        tbl[4]  = '{1, 0, 1, 1, 1,   0, 1, 1, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 1};
        tbl[6]  = '{1, 0, 1, 0, 1,   0, 0, 1, 0, 1};
        tbl[7]  = '{1, 1, 1, 0, 0,   1, 0, 0, 1, 1};
        tbl[8]  = '{1, 0, 1, 0, 0,   1, 0, 0, 1, 0};
        tbl[9]  = '{1, 0, 1, 1, 1,   0, 1, 1, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 0};
        tbl[11] = '{1, 1, 0, 0, 1,   1, 0, 0, 1, 1};
        tbl[12] = '{1, 1, 1, 0, 0,   1, 0, 0, 1, 0};
        tbl[13] = '{1, 1, 1, 0, 1,   0, 1, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 1,   0, 0, 0, 1, 0};

        foreach (tbl[i]) begin
            reset1 = tbl[i].rst;
            b1.load_start = tbl[i].start; b1.load_valid = tbl[i].valid;
            b1.load_bit = tbl[i].bitv;    b1.addr = tbl[i].addr;
            @(posedge clock); #1;
            chk($sformatf("v%0d.ready", i), b1.load_ready, tbl[i].ready);
            chk($sformatf("v%0d.done", i),  b1.load_done,  tbl[i].done);
            chk($sformatf("v%0d.cpu", i),   cpu1,          tbl[i].cpu);
            chk($sformatf("v%0d.busy", i),  busy1,         tbl[i].busy);
            chk($sformatf("v%0d.data", i),  b1.data,       tbl[i].data);
        end
        b1.addr = 1'b0; #1;
        chk("v.rst_data0", b1.data, 1'b0);

        // 8-entry load with a gap cycle after every bit.
        reset3 = 0;
        step3("g.rst", 0, 0, 0, 0);
        step3("g.rst", 0, 1, 1, 5);
        reset3 = 1;
        step3("g.start", 1, 0, 0, 0);
        prog = 8'b0100_1011;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (b3.load_ready) acc++;
            step3("g.bit", 0, 1, prog[i], 3'(i));
            if (i == 7) chk("g.done_after_last", b3.load_done, 1'b1);
            else        chk("g.no_early_done", b3.load_done, 1'b0);
            step3("g.gap", 0, 0, 0, 3'(i));
        end
        chk("g.accepts", acc, 8);
        read_all3(rd);
        chk("g.readback", rd, 8'h4B);

        // Valid while running must not write.
        step3("r.ignore", 0, 1, 1, 2);
        step3("r.ignore", 0, 1, 0, 0);
        read_all3(rd);
        chk("r.unchanged", rd, 8'h4B);

        // Reset after three accepted bits of a reload.
        step3("m.start", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step3("m.bit", 0, 1, 1, 3'(i));
        reset3 = 0;
        step3("m.rst", 0, 1, 1, 0);
        reset3 = 1;
        read_all3(rd);
        chk("m.cleared", rd, 8'h00);
        chk("m.cpu_held", cpu3, 1'b0);
        step3("m.idle_valid", 0, 1, 1, 0);
        step3("m.start2", 1, 1, 1, 0);
        prog = 8'b1001_0110;
        for (int i = 0; i < 8; i++) step3("m.bit2", 0, 1, prog[i], 3'(i));
        chk("m.cpu_run", cpu3, 1'b1);
        read_all3(rd);
        chk("m.readback", rd, prog);

        // Random traffic, occasional resets and restarts.
        for (int i = 0; i < 3000; i++) begin
            reset3 = ($urandom_range(0, 299) != 0);
            step3("rnd", $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/onebit_progmem.md
# onebit_progmem

Program memory and loader sitting directly upstream of the one-bit CPU. Holds a 2**ADDR_W-entry, 1-bit-wide instruction store. The store is written serially over a valid/ready load port and read combinationally by the CPU's `addr`/`data` fetch path. Owns the CPU's reset, holding the core in reset until a full program has been loaded, so the core never fetches a partially written program.

## Interface
- `ADDR_W`, default 1: fetch address width; store depth DEPTH = 2**ADDR_W (default 2, matching the CPU's 1-bit `addr`).

Ports:
- `clock`: in, 1. Clock.
- `reset`: in, 1. Synchronous, active-low; `clock` is the clock.
- `load_start`: in, 1. Request to (re)load the full program.
- `load_valid`: in, 1. `load_bit` is valid.
- `load_bit`: in, 1. Next program bit, address order 0..DEPTH-1.
- `load_ready`: out, 1. Loader accepts a bit this cycle.
- `load_done`: out, 1. One-cycle pulse when the last bit has been written.
- `addr`: in, ADDR_W. CPU fetch address.
- `data`: out, 1. Instruction bit at `addr`; combinational read.
- `cpu_reset`: out, 1. Active-low reset to the CPU; registered.
- `busy`: out, 1. High in IDLE and LOAD.

## Operation
- State machine has three states: IDLE, LOAD, RUN.
- Reset (`reset`=0 at a clock edge):
  - state goes to IDLE; write pointer `wptr`=0.
  - all DEPTH memory bits are cleared to 0.
  - `cpu_reset`=0, `load_done`=0; outputs therefore read `load_ready`=0, `busy`=1, `data`=0.
- IDLE:
  - `load_start`=1 moves to LOAD with `wptr`=0.
  - `load_valid` is ignored.
- LOAD:
  - `load_ready`=1.
  - Each cycle with `load_valid`&`load_ready`: mem[`wptr`] <= `load_bit`, then `wptr` increments.
  - The accept at `wptr`=DEPTH-1 moves to RUN and `wptr` wraps to 0.
  - `load_start` is ignored in LOAD; a load is never restarted mid-stream.
- RUN:
  - `load_ready`=0, `busy`=0, `cpu_reset`=1.
  - `load_start`=1 moves to LOAD with `wptr`=0. `cpu_reset` drops to 0 on that same edge, so the CPU is reset from the next cycle on.
  - Memory contents are retained until overwritten.
- `data` = mem[`addr`] in every state.
  - A write is visible on `data` from the cycle after the accepting edge.
- `load_done` is registered: high for exactly one cycle, starting the edge on which state becomes RUN.
- `wptr` width is ADDR_W; the wrap from DEPTH-1 to 0 is natural modular arithmetic.

## Timing
- Accept latency: a bit presented with `load_valid`=1 in LOAD is written at that clock edge. Throughput is one bit per cycle.
- `load_ready` is a decode of state only. It never depends on `load_valid`, so there is no combinational loop.
- `cpu_reset` rises on the same edge as entry to RUN. The CPU's first un-reset edge is one cycle later, and it fetches mem[0] with the full program in place.
- Full load from IDLE with `load_valid` held high:
  - cycle 0: `load_start` seen.
  - cycles 1..DEPTH: bits accepted.
  - `load_done`=1 and `cpu_reset`=1 during cycle DEPTH+1.
- Gaps in `load_valid` stretch the load by one cycle per gap cycle. No timeout.
- `load_start` and `load_valid` asserted together in IDLE or RUN: only the start is taken. That bit is not accepted because `load_ready`=0 that cycle.
- Reset mid-LOAD or mid-RUN: takes priority over all inputs. Same result as power-on reset: memory cleared, IDLE, CPU held.
- `addr` outside DEPTH cannot occur; the width equals ADDR_W.

## Test plan
- Power-on: hold `reset`=0 for 2 cycles → `cpu_reset`=0, `load_ready`=0, `load_done`=0, `busy`=1, `data`=0 for `addr`=0 and `addr`=1.
- ADDR_W=1 load: `load_start`, then bits 1,0 back-to-back →
  - `load_ready`=1 for 2 cycles.
  - `load_done` pulses once, with `cpu_reset`=1 in the same cycle.
  - Afterwards `addr`=0 gives `data`=1 and `addr`=1 gives `data`=0.
- Backpressure gaps, ADDR_W=3: bits 1,1,0,1,0,0,1,0 with `load_valid` low on alternate cycles →
  - mem reads back 8'b01001011, LSB = address 0.
  - `load_done` pulses exactly one cycle after the 8th accept.
  - Exactly 8 writes occur.
- Reload from RUN:
  - program 1,1, then `load_start` → next cycle `cpu_reset`=0, `load_ready`=1, old data still readable.
  - load 0,1 → `data`=0 at `addr`=0 and 1 at `addr`=1; `cpu_reset` returns to 1.
- Ignored requests:
  - `load_start` pulses during LOAD → no `wptr` reset; the load completes after DEPTH total accepts.
  - `load_valid` in RUN → memory unchanged.
- Reset mid-load (ADDR_W=3): after 3 accepted bits, `reset`=0 for 1 cycle → state IDLE, all 8 bits read 0, `cpu_reset`=0. A fresh 8-bit load then completes normally.
